xaui_link_bringup: RTL and testbench
====================================

# xaui_link_bringup

Parametrised per-quad link bring-up sequencer for the K7 XAUI MGT infrastructure, in the `xaui_clk` domain between the transceiver wrapper and the XAUI cores. One independent state machine per enabled quad drives the following signals in order:
- PMA reset
- datapath resets
- comma alignment
- channel bonding

It watches lock, reset-done and sync status, and retries on timeout or link loss. It replaces the fixed reset-only scheme with a configurable quad count, per-stage timeouts, loss-of-link recovery and per-quad retry statistics.

## Interface
- `NUM_QUADS`, 8, number of quad slots (1–8).
- `ENABLE`, `{NUM_QUADS{1'b1}}`, per-quad enable mask. A disabled slot is held in `RESET` permanently.
- `PMA_CYCLES`, 64, cycles that `pma_reset` is held asserted per attempt (≥1).
- `DP_CYCLES`, 16, cycles that `mgt_rx_rst`/`mgt_tx_rst` are held asserted (≥1).
- `BOND_CYCLES`, 32, cycles that `mgt_rxenchansync` is held before checking the bond.
- `TIMEOUT`, 100000, maximum cycles spent in any `WAIT_*`/`ALIGN` state.
- `LOSS_CYCLES`, 256, consecutive bad cycles in `UP` that trigger recovery.
- `TIMER_W`, 20, timer width. Must satisfy 2^`TIMER_W` > max(`TIMEOUT`, `PMA_CYCLES`, `LOSS_CYCLES`).
- `xaui_clk`  in  1  sole clock; every signal is sampled/driven on its rising edge.
- `mgt_reset`  in  1  synchronous, active-high reset.
- `mgt_rxlock`  in  4·N  per-lane RX PLL lock.
- `mgt_rx_resetdone`  in  4·N  per-lane RX reset done.
- `mgt_tx_resetdone`  in  4·N  per-lane TX reset done.
- `mgt_rxsyncok`  in  4·N  per-lane sync ok (loss-of-sync inverted).
- `pma_reset`  out  N  per-quad GTX/PLL reset.
- `mgt_rx_rst`  out  N  per-quad RX datapath reset.
- `mgt_tx_rst`  out  N  per-quad TX datapath reset.
- `mgt_rxencommaalign`  out  4·N  per-lane comma-align enable.
- `mgt_rxenchansync`  out  N  per-quad channel-bond enable.
- `link_up`  out  N  quad fully bonded and stable.
- `retry_count`  out  8·N  per-quad saturating retry counter.
- `bringup_state`  out  3·N  current state code per quad.

## Operation
- State codes:
  - `RESET`=0
  - `PMA_RST`=1
  - `WAIT_LOCK`=2
  - `DP_RST`=3
  - `WAIT_DONE`=4
  - `ALIGN`=5
  - `BOND`=6
  - `UP`=7
- Reset values of all outputs:
  - `pma_reset`, `mgt_rx_rst`, `mgt_tx_rst` = all ones.
  - `mgt_rxencommaalign`, `mgt_rxenchansync`, `link_up`, `retry_count` = 0.
  - `bringup_state` = 0.
- Per-quad timer: cleared on every state entry; increments each cycle otherwise; saturates at all-ones.
- `RESET`: all resets asserted. Goes to `PMA_RST` on the next cycle if `ENABLE[q]` is set; otherwise stays.
- `PMA_RST`: `pma_reset`=1, dp resets=1. After `PMA_CYCLES` cycles → `WAIT_LOCK`.
- `WAIT_LOCK`: `pma_reset`=0. All 4 `mgt_rxlock` high → `DP_RST`. Timer = `TIMEOUT` → retry.
- `DP_RST`: `mgt_rx_rst`=`mgt_tx_rst`=1. After `DP_CYCLES` cycles → `WAIT_DONE`.
- `WAIT_DONE`: dp resets=0. All 8 resetdone bits high → `ALIGN`. Timeout → retry.
- `ALIGN`: `mgt_rxencommaalign[q]`=4'hF. All 4 syncok high → `BOND`. Timeout → retry.
- `BOND`: commaalign held at 4'hF; `mgt_rxenchansync`=1. After `BOND_CYCLES` cycles:
  - all syncok high → `UP`;
  - otherwise → retry.
- `UP`: `link_up`=1, `mgt_rxenchansync`=1, commaalign=0.
  - A bad cycle is one where any lock or syncok bit is low.
  - A loss counter counts consecutive bad cycles and clears on any good cycle.
  - Reaching `LOSS_CYCLES` → retry.
- Retry: `retry_count[q]` += 1, saturating at 255; next state is `PMA_RST`.
- Priority when advance and timeout coincide in the same cycle: advance wins.
- Quads are fully independent; no cross-quad coupling.

## Timing
- All outputs are registered and driven as a function of the registered state.
- A condition sampled at edge k changes the state at edge k; outputs reflect it from that edge.
- Hold times are exact:
  - `pma_reset` is high for exactly `PMA_CYCLES` cycles in `PMA_RST`;
  - the dp resets are high for exactly `DP_CYCLES` cycles in `DP_RST`;
  - `mgt_rxenchansync` is high for exactly `BOND_CYCLES` cycles in `BOND` before the check.
- Timeout fires in the cycle the timer equals `TIMEOUT`, i.e. the state is left after `TIMEOUT`+1 cycles.
- `mgt_reset` asserted mid-operation: on the next edge every quad returns to `RESET`, all outputs take reset values, and `retry_count` clears.
- Minimum bring-up latency with ideal inputs: `PMA_CYCLES`+`DP_CYCLES`+`BOND_CYCLES`+4 cycles from reset release to `link_up`.

## Structure
- Package `xaui_bringup_pkg`: state encoding constants, state width (3), lanes-per-quad (4), retry counter width (8).
- Sub-module `xaui_bringup_quad` holds one FSM, its timer, loss counter and retry counter.
- The top level uses generate over `NUM_QUADS`, gated by `ENABLE`, and does the bus slicing.

## Test plan
Bench parameters: N=2, `PMA_CYCLES`=4, `DP_CYCLES`=2, `BOND_CYCLES`=3, `TIMEOUT`=16, `LOSS_CYCLES`=5.
- **Ideal inputs:** all status inputs tied high, reset released → `link_up`=2'b11 at cycle 13, `retry_count`=0, `pma_reset` high exactly 4 cycles after `RESET`.
- **Lock timeout:** quad 1 lock held at 4'b0111 → quad 1 returns to `PMA_RST` after 17 cycles in `WAIT_LOCK` and `retry_count[1]` increments each attempt; quad 0 reaches `UP` unaffected.
- **Loss debounce:** in `UP`, drop syncok lane 2 of quad 0 for 4 cycles → no retry; then drop it for 5 consecutive cycles → retry, `link_up[0]`=0, `retry_count[0]`=1.
- **Simultaneous events:** all syncok rise in the same cycle as the `ALIGN` timeout → goes to `BOND`, no retry counted.
- **Saturation and reset:** force 300 lock timeouts → `retry_count` saturates at 8'hFF. Assert `mgt_reset` mid-`BOND` → next edge gives state 0, all resets high, count 0.
- **Disabled slot:** `ENABLE`=2'b01 → quad 1 stays in `RESET` with outputs at reset values indefinitely.

Source files
------------

// File: rtl/xaui_bringup_pkg.sv
// rtl/xaui_bringup_pkg.sv - shared constants and state encoding for the XAUI link bring-up sequencer
package xaui_bringup_pkg;

  localparam int STATE_W = 3;
  localparam int LANES   = 4;
  localparam int RETRY_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET     = 3'd0,
    ST_PMA_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_DP_RST    = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_ALIGN     = 3'd5,
    ST_BOND      = 3'd6,
    ST_UP        = 3'd7
  } state_t;

endpackage

// File: rtl/xaui_bringup_quad.sv
// rtl/xaui_bringup_quad.sv - one quad's bring-up FSM with stage timer, loss debounce and retry counter
module xaui_bringup_quad
  import xaui_bringup_pkg::*;
#(
  parameter bit QUAD_EN     = 1'b1,
  parameter int PMA_CYCLES  = 64,
  parameter int DP_CYCLES   = 16,
  parameter int BOND_CYCLES = 32,
  parameter int TIMEOUT     = 100000,
  parameter int LOSS_CYCLES = 256,
  parameter int TIMER_W     = 20
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [LANES-1:0]   i_rxlock,
  input  logic [LANES-1:0]   i_rx_resetdone,
  input  logic [LANES-1:0]   i_tx_resetdone,
  input  logic [LANES-1:0]   i_rxsyncok,
  output logic               o_pma_reset,
  output logic               o_rx_rst,
  output logic               o_tx_rst,
  output logic [LANES-1:0]   o_commaalign,
  output logic               o_chansync,
  output logic               o_link_up,
  output logic [RETRY_W-1:0] o_retry_count,
  output logic [STATE_W-1:0] o_state
);

  // Timer compare points: hold states leave when the timer shows the last held cycle.
  localparam logic [TIMER_W-1:0] W_ONE       = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] W_PMA_LAST  = TIMER_W'(PMA_CYCLES - 1);
  localparam logic [TIMER_W-1:0] W_DP_LAST   = TIMER_W'(DP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] W_BOND_LAST = TIMER_W'(BOND_CYCLES - 1);
  localparam logic [TIMER_W-1:0] W_TMO       = TIMER_W'(TIMEOUT);
  localparam logic [TIMER_W-1:0] W_LOSS_LAST = TIMER_W'(LOSS_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TIMER_W-1:0]   r_timer;
  logic [TIMER_W-1:0]   r_loss;
  logic [RETRY_W-1:0]   r_retry;
  logic                 r_pma_reset;
  logic                 r_dp_rst;
  logic [LANES-1:0]     r_commaalign;
  logic                 r_chansync;
  logic                 r_link_up;
  logic                 w_retry;
  logic                 w_enter;

  logic w_all_lock;
  logic w_all_done;
  logic w_all_sync;
  logic w_bad;

  assign w_all_lock = &i_rxlock;
  assign w_all_done = (&i_rx_resetdone) & (&i_tx_resetdone);
  assign w_all_sync = &i_rxsyncok;
  assign w_bad      = ~(w_all_lock & w_all_sync);
  assign w_enter    = (w_state_nxt != r_state);

  // Next state: an advance condition is tested before the timeout, so advance wins a tie.
  always_comb begin
    w_state_nxt = r_state;
    w_retry     = 1'b0;
    case (r_state)
      ST_RESET:     if (QUAD_EN) w_state_nxt = ST_PMA_RST;
      ST_PMA_RST:   if (r_timer == W_PMA_LAST) w_state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (w_all_lock)            w_state_nxt = ST_DP_RST;
        else if (r_timer == W_TMO) w_retry = 1'b1;
      end
      ST_DP_RST:    if (r_timer == W_DP_LAST) w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (w_all_done)            w_state_nxt = ST_ALIGN;
        else if (r_timer == W_TMO) w_retry = 1'b1;
      end
      ST_ALIGN: begin
        if (w_all_sync)            w_state_nxt = ST_BOND;
        else if (r_timer == W_TMO) w_retry = 1'b1;
      end
      ST_BOND: begin
        if (r_timer == W_BOND_LAST) begin
          if (w_all_sync) w_state_nxt = ST_UP;
          else            w_retry = 1'b1;
        end
      end
      ST_UP:        if (w_bad && (r_loss == W_LOSS_LAST)) w_retry = 1'b1;
      default:      w_state_nxt = ST_RESET;
    endcase
    if (w_retry) w_state_nxt = ST_PMA_RST;
  end

  // State, counters, and outputs registered from the next state so they change with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_RESET;
      r_timer      <= '0;
      r_loss       <= '0;
      r_retry      <= '0;
      r_pma_reset  <= 1'b1;
      r_dp_rst     <= 1'b1;
      r_commaalign <= '0;
      r_chansync   <= 1'b0;
      r_link_up    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_enter)             r_timer <= '0;
      else if (r_timer != '1)  r_timer <= r_timer + W_ONE;

      if (w_enter || !w_bad || (r_state != ST_UP)) r_loss <= '0;
      else                                         r_loss <= r_loss + W_ONE;

      if (w_retry && (r_retry != '1)) r_retry <= r_retry + RETRY_W'(1);

      r_pma_reset  <= (w_state_nxt inside {ST_RESET, ST_PMA_RST});
      r_dp_rst     <= (w_state_nxt inside {ST_RESET, ST_PMA_RST, ST_WAIT_LOCK, ST_DP_RST});
      r_commaalign <= (w_state_nxt inside {ST_ALIGN, ST_BOND}) ? '1 : '0;
      r_chansync   <= (w_state_nxt inside {ST_BOND, ST_UP});
      r_link_up    <= (w_state_nxt == ST_UP);
    end
  end

  assign o_pma_reset   = r_pma_reset;
  assign o_rx_rst      = r_dp_rst;
  assign o_tx_rst      = r_dp_rst;
  assign o_commaalign  = r_commaalign;
  assign o_chansync    = r_chansync;
  assign o_link_up     = r_link_up;
  assign o_retry_count = r_retry;
  assign o_state       = r_state;

endmodule

// File: rtl/xaui_link_bringup.sv
// rtl/xaui_link_bringup.sv - per-quad XAUI MGT bring-up sequencer top with bus slicing
module xaui_link_bringup
  import xaui_bringup_pkg::*;
#(
  parameter int                   NUM_QUADS   = 8,
  parameter logic [NUM_QUADS-1:0] ENABLE      = {NUM_QUADS{1'b1}},
  parameter int                   PMA_CYCLES  = 64,
  parameter int                   DP_CYCLES   = 16,
  parameter int                   BOND_CYCLES = 32,
  parameter int                   TIMEOUT     = 100000,
  parameter int                   LOSS_CYCLES = 256,
  parameter int                   TIMER_W     = 20
) (
  input  logic                         xaui_clk,
  input  logic                         mgt_reset,
  input  logic [LANES*NUM_QUADS-1:0]   mgt_rxlock,
  input  logic [LANES*NUM_QUADS-1:0]   mgt_rx_resetdone,
  input  logic [LANES*NUM_QUADS-1:0]   mgt_tx_resetdone,
  input  logic [LANES*NUM_QUADS-1:0]   mgt_rxsyncok,
  output logic [NUM_QUADS-1:0]         pma_reset,
  output logic [NUM_QUADS-1:0]         mgt_rx_rst,
  output logic [NUM_QUADS-1:0]         mgt_tx_rst,
  output logic [LANES*NUM_QUADS-1:0]   mgt_rxencommaalign,
  output logic [NUM_QUADS-1:0]         mgt_rxenchansync,
  output logic [NUM_QUADS-1:0]         link_up,
  output logic [RETRY_W*NUM_QUADS-1:0] retry_count,
  output logic [STATE_W*NUM_QUADS-1:0] bringup_state
);

  // One independent sequencer per quad slot; a disabled slot parks in RESET.
  for (genvar q = 0; q < NUM_QUADS; q++) begin : g_quad
    xaui_bringup_quad #(
      .QUAD_EN     (ENABLE[q]),
      .PMA_CYCLES  (PMA_CYCLES),
      .DP_CYCLES   (DP_CYCLES),
      .BOND_CYCLES (BOND_CYCLES),
      .TIMEOUT     (TIMEOUT),
      .LOSS_CYCLES (LOSS_CYCLES),
      .TIMER_W     (TIMER_W)
    ) u_quad (
      .i_clk          (xaui_clk),
      .i_rst          (mgt_reset),
      .i_rxlock       (mgt_rxlock[LANES*q +: LANES]),
      .i_rx_resetdone (mgt_rx_resetdone[LANES*q +: LANES]),
      .i_tx_resetdone (mgt_tx_resetdone[LANES*q +: LANES]),
      .i_rxsyncok     (mgt_rxsyncok[LANES*q +: LANES]),
      .o_pma_reset    (pma_reset[q]),
      .o_rx_rst       (mgt_rx_rst[q]),
      .o_tx_rst       (mgt_tx_rst[q]),
      .o_commaalign   (mgt_rxencommaalign[LANES*q +: LANES]),
      .o_chansync     (mgt_rxenchansync[q]),
      .o_link_up      (link_up[q]),
      .o_retry_count  (retry_count[RETRY_W*q +: RETRY_W]),
      .o_state        (bringup_state[STATE_W*q +: STATE_W])
    );
  end

endmodule

// File: tb/tb_xaui_link_bringup.sv
// tb/tb_xaui_link_bringup.sv - self-checking bench for xaui_link_bringup against a cycle-count reference model
module tb_xaui_link_bringup;

  localparam int N    = 2;
  localparam int PMA  = 4;
  localparam int DP   = 2;
  localparam int BOND = 3;
  localparam int TMO  = 16;
  localparam int LOSS = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [4*N-1:0] lock, rxd, txd, sync;

  logic [N-1:0]   pma, rxr, txr, chs, up;
  logic [4*N-1:0] cm;
  logic [8*N-1:0] rc;
  logic [3*N-1:0] st;

  logic [N-1:0]   pma_d, rxr_d, txr_d, chs_d, up_d;
  logic [4*N-1:0] cm_d;
  logic [8*N-1:0] rc_d;
  logic [3*N-1:0] st_d;

  xaui_link_bringup #(
    .NUM_QUADS(N), .ENABLE(2'b11), .PMA_CYCLES(PMA), .DP_CYCLES(DP), .BOND_CYCLES(BOND),
    .TIMEOUT(TMO), .LOSS_CYCLES(LOSS), .TIMER_W(20)
  ) dut (
    .xaui_clk(clk), .mgt_reset(rst), .mgt_rxlock(lock), .mgt_rx_resetdone(rxd),
    .mgt_tx_resetdone(txd), .mgt_rxsyncok(sync), .pma_reset(pma), .mgt_rx_rst(rxr),
    .mgt_tx_rst(txr), .mgt_rxencommaalign(cm), .mgt_rxenchansync(chs), .link_up(up),
    .retry_count(rc), .bringup_state(st)
  );

  xaui_link_bringup #(
    .NUM_QUADS(N), .ENABLE(2'b01), .PMA_CYCLES(PMA), .DP_CYCLES(DP), .BOND_CYCLES(BOND),
    .TIMEOUT(TMO), .LOSS_CYCLES(LOSS), .TIMER_W(20)
  ) dut_dis (
    .xaui_clk(clk), .mgt_reset(rst), .mgt_rxlock(lock), .mgt_rx_resetdone(rxd),
    .mgt_tx_resetdone(txd), .mgt_rxsyncok(sync), .pma_reset(pma_d), .mgt_rx_rst(rxr_d),
    .mgt_tx_rst(txr_d), .mgt_rxencommaalign(cm_d), .mgt_rxenchansync(chs_d), .link_up(up_d),
    .retry_count(rc_d), .bringup_state(st_d)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: per quad, the stage, the edge it was entered on, the last healthy
  // edge while up, and the retry total. Stage durations come from edge arithmetic.
  int cyc;
  int m_st   [N];
  int m_t0   [N];
  int m_good [N];
  int m_rc   [N];

  task automatic model_step();
    cyc++;
    for (int q = 0; q < N; q++) begin
      bit lk, dn, sy, rtry;
      int age, nxt;
      lk   = &lock[4*q +: 4];
      dn   = (&rxd[4*q +: 4]) && (&txd[4*q +: 4]);
      sy   = &sync[4*q +: 4];
      age  = cyc - m_t0[q];
      nxt  = m_st[q];
      rtry = 1'b0;
      if (rst) begin
        m_st[q] = 0; m_t0[q] = cyc; m_good[q] = cyc; m_rc[q] = 0;
      end else begin
        case (m_st[q])
          0: nxt = 1;
          1: if (age == PMA) nxt = 2;
          2: if (lk) nxt = 3; else if (age == TMO + 1) rtry = 1'b1;
          3: if (age == DP) nxt = 4;
          4: if (dn) nxt = 5; else if (age == TMO + 1) rtry = 1'b1;
          5: if (sy) nxt = 6; else if (age == TMO + 1) rtry = 1'b1;
          6: if (age == BOND) begin if (sy) nxt = 7; else rtry = 1'b1; end
          default: begin
            if (lk && sy) m_good[q] = cyc;
            else if (cyc - m_good[q] == LOSS) rtry = 1'b1;
          end
        endcase
        if (rtry) begin
          nxt = 1;
          if (m_rc[q] < 255) m_rc[q]++;
        end
        if (nxt != m_st[q]) begin
          m_st[q] = nxt; m_t0[q] = cyc; m_good[q] = cyc;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0]   e_pma, e_dp, e_ch, e_up;
    logic [4*N-1:0] e_cm;
    logic [8*N-1:0] e_rc;
    logic [3*N-1:0] e_st;
    for (int q = 0; q < N; q++) begin
      int s;
      s = m_st[q];
      e_pma[q]        = (s <= 1);
      e_dp[q]         = (s <= 3);
      e_cm[4*q +: 4]  = (s == 5 || s == 6) ? 4'hF : 4'h0;
      e_ch[q]         = (s >= 6);
      e_up[q]         = (s == 7);
      e_rc[8*q +: 8]  = m_rc[q][7:0];
      e_st[3*q +: 3]  = s[2:0];
    end
    check_eq("pma_reset", pma, e_pma);
    check_eq("mgt_rx_rst", rxr, e_dp);
    check_eq("mgt_tx_rst", txr, e_dp);
    check_eq("commaalign", cm, e_cm);
    check_eq("chansync", chs, e_ch);
    check_eq("link_up", up, e_up);
    check_eq("retry_count", rc, e_rc);
    check_eq("bringup_state", st, e_st);
    check_eq("dis.pma_reset", pma_d, {1'b1, e_pma[0]});
    check_eq("dis.mgt_rx_rst", rxr_d, {1'b1, e_dp[0]});
    check_eq("dis.mgt_tx_rst", txr_d, {1'b1, e_dp[0]});
    check_eq("dis.commaalign", cm_d, {4'h0, e_cm[3:0]});
    check_eq("dis.chansync", chs_d, {1'b0, e_ch[0]});
    check_eq("dis.link_up", up_d, {1'b0, e_up[0]});
    check_eq("dis.retry_count", rc_d, {8'h00, e_rc[7:0]});
    check_eq("dis.bringup_state", st_d, {3'd0, e_st[2:0]});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    lock = '1; rxd = '1; txd = '1; sync = '1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, w, p;
    rst = 1'b1;
    lock = '1; rxd = '1; txd = '1; sync = '1;
    cyc = 0;
    for (int q = 0; q < N; q++) begin
      m_st[q] = 0; m_t0[q] = 0; m_good[q] = 0; m_rc[q] = 0;
    end
    @(negedge clk);

    // Reset values
    tick();
    tick();
    check_eq("rst.state", st, 6'd0);
    check_eq("rst.pma", pma, 2'b11);
    check_eq("rst.rx_rst", rxr, 2'b11);
    check_eq("rst.tx_rst", txr, 2'b11);
    check_eq("rst.comma", cm, 8'h00);
    check_eq("rst.chansync", chs, 2'b00);
    check_eq("rst.link_up", up, 2'b00);
    check_eq("rst.retry", rc, 16'h0000);

    // Ideal inputs: link up at edge 13, pma_reset held 4 cycles
    rst = 1'b0;
    hi = 0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (pma[0]) hi++;
      if (k == 12) check_eq("ideal.up_at_12", up, 2'b00);
    end
    check_eq("ideal.up_at_13", up, 2'b11);
    check_eq("ideal.pma_cycles", hi, 4);
    check_eq("ideal.retry", rc, 16'h0000);

    // Lock timeout on quad 1
    apply_reset();
    lock[7:4] = 4'b0111;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k == 21) check_eq("lock.still_wait", st[5:3], 3'd2);
      if (k == 22) begin
        check_eq("lock.back_to_pma", st[5:3], 3'd1);
        check_eq("lock.retry1", rc[15:8], 8'd1);
      end
    end
    check_eq("lock.retry2", rc[15:8], 8'd2);
    check_eq("lock.q0_up", up[0], 1'b1);
    check_eq("lock.q0_retry", rc[7:0], 8'd0);

    // Loss debounce on quad 0 lane 2
    sync[2] = 1'b0;
    repeat (4) tick();
    sync[2] = 1'b1;
    repeat (3) tick();
    check_eq("loss4.up", up[0], 1'b1);
    check_eq("loss4.retry", rc[7:0], 8'd0);
    sync[2] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 4) check_eq("loss5.up_before", up[0], 1'b1);
    end
    check_eq("loss5.up", up[0], 1'b0);
    check_eq("loss5.retry", rc[7:0], 8'd1);
    check_eq("loss5.state", st[2:0], 3'd1);
    sync[2] = 1'b1;

    // Sync arrives on the same edge as the ALIGN timeout: advance wins
    apply_reset();
    sync[3:0] = 4'h0;
    repeat (25) tick();
    check_eq("simul.align", st[2:0], 3'd5);
    sync[3:0] = 4'hF;
    tick();
    check_eq("simul.bond", st[2:0], 3'd6);
    check_eq("simul.retry", rc[7:0], 8'd0);

    // Control: no sync by the timeout edge gives a retry
    apply_reset();
    sync[3:0] = 4'h0;
    repeat (26) tick();
    check_eq("align_tmo.state", st[2:0], 3'd1);
    check_eq("align_tmo.retry", rc[7:0], 8'd1);

    // Saturation after 300 lock timeouts, then reset mid-BOND
    apply_reset();
    lock = '0;
    repeat (300 * 21 + 10) tick();
    check_eq("sat.retry", rc, 16'hFFFF);
    lock = '1;
    w = 0;
    while (st[2:0] != 3'd6 && w < 100) begin
      tick();
      w++;
    end
    check_eq("sat.reach_bond", st[2:0], 3'd6);
    check_eq("sat.retry_kept", rc[7:0], 8'hFF);
    rst = 1'b1;
    tick();
    check_eq("midrst.state", st, 6'd0);
    check_eq("midrst.pma", pma, 2'b11);
    check_eq("midrst.rx_rst", rxr, 2'b11);
    check_eq("midrst.tx_rst", txr, 2'b11);
    check_eq("midrst.retry", rc, 16'h0000);
    rst = 1'b0;

    // Randomized status inputs in segments of varying health
    for (int seg = 0; seg < 6; seg++) begin
      case (seg % 3)
        0:       p = 97;
        1:       p = 85;
        default: p = 60;
      endcase
      for (int k = 0; k < 500; k++) begin
        for (int q = 0; q < N; q++) begin
          lock[4*q +: 4] = ($urandom_range(0, 99) < p) ? 4'hF : 4'($urandom);
          rxd[4*q +: 4]  = ($urandom_range(0, 99) < p) ? 4'hF : 4'($urandom);
          txd[4*q +: 4]  = ($urandom_range(0, 99) < p) ? 4'hF : 4'($urandom);
          sync[4*q +: 4] = ($urandom_range(0, 99) < p) ? 4'hF : 4'($urandom);
        end
        rst = ($urandom_range(0, 999) == 0);
        tick();
      end
    end

    // Disabled slot stays parked
    check_eq("dis.q1_state", st_d[5:3], 3'd0);
    check_eq("dis.q1_pma", pma_d[1], 1'b1);
    check_eq("dis.q1_retry", rc_d[15:8], 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
